// File: rtl/muldiv_if.sv
// EX-stage request/result bundle for the iterative multiply/divide sequencer.
// The pipeline side is the master; muldiv_ctrl is the slave.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] mf_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid, funct, src_a, src_b,
        input  stall, busy, done, mf_data, hi, lo
    );

    modport slave (
        input  valid, funct, src_a, src_b,
        output stall, busy, done, mf_data, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULTU/DIVU sequencer owning HI/LO, one datapath step per cycle.
// Define MULDIV_SIGNED_EN to add signed MULT/DIV; otherwise funct 24/26 run unsigned.
module muldiv_ctrl #(
    parameter int         WIDTH   = 32,
    parameter logic [5:0] F_MFHI  = 6'd16,
    parameter logic [5:0] F_MFLO  = 6'd18,
    parameter logic [5:0] F_MULTU = 6'd25,
    parameter logic [5:0] F_DIVU  = 6'd27
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int         CNT_W  = $clog2(WIDTH);
    localparam logic [5:0] F_MULT = 6'd24;
    localparam logic [5:0] F_DIV  = 6'd26;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] acc_q, sh_q, opnd_q;
    logic             op_div_q;

    logic             is_mul, is_div, is_mf, is_md;
    logic             stall, accept, last;
    logic [WIDTH-1:0] a_ld, b_ld;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] acc_nx, sh_nx;
    logic [WIDTH-1:0] hi_res, lo_res;
    logic [WIDTH-1:0] mf_data;

    always_comb begin
        is_mul = (bus.funct == F_MULTU) || (bus.funct == F_MULT);
        is_div = (bus.funct == F_DIVU)  || (bus.funct == F_DIV);
        is_mf  = (bus.funct == F_MFHI)  || (bus.funct == F_MFLO);
        is_md  = is_mul || is_div;
        stall  = busy_q && bus.valid && (is_md || is_mf);
        accept = bus.valid && is_md && !stall && (state_q != RUN);
        last   = (state_q == RUN) && (count_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MULDIV_SIGNED_EN
    logic             op_sgn;
    logic             sgn_q, neg_a_q, neg_b_q, b_zero_q;
    logic [WIDTH-1:0] raw_a_q;
    logic [2*WIDTH-1:0] prod;

    // Signed ops iterate on magnitudes; the sign is reapplied at commit.
    always_comb begin
        op_sgn = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        a_ld   = (op_sgn && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
        b_ld   = (op_sgn && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            raw_a_q  <= '0;
        end else if (accept) begin
            sgn_q    <= op_sgn;
            neg_a_q  <= op_sgn && bus.src_a[WIDTH-1];
            neg_b_q  <= op_sgn && bus.src_b[WIDTH-1];
            b_zero_q <= (bus.src_b == '0);
            raw_a_q  <= bus.src_a;
        end
    end

    always_comb begin
        prod   = {acc_nx, sh_nx};
        hi_res = acc_nx;
        lo_res = sh_nx;
        if (sgn_q) begin
            if (!op_div_q) begin
                if (neg_a_q ^ neg_b_q) prod = -prod;
                hi_res = prod[2*WIDTH-1:WIDTH];
                lo_res = prod[WIDTH-1:0];
            end else if (b_zero_q) begin
                hi_res = raw_a_q;
                lo_res = '1;
            end else begin
                if (neg_a_q ^ neg_b_q) lo_res = -sh_nx;
                if (neg_a_q) hi_res = -acc_nx;
            end
        end
    end
`else
    assign a_ld   = bus.src_a;
    assign b_ld   = bus.src_b;
    assign hi_res = acc_nx;
    assign lo_res = sh_nx;
`endif

    // acc holds the running high product / partial remainder; sh holds the
    // multiplier bits still to consume, or the dividend shifting into quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, sh_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (op_div_q) begin
            acc_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
            sh_nx  = {sh_q[WIDTH-2:0], div_ge};
        end else begin
            acc_nx = mul_sum[WIDTH:1];
            sh_nx  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opnd_q   <= '0;
            op_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
            if (accept) begin
                count_q  <= '0;
                acc_q    <= '0;
                op_div_q <= is_div;
                sh_q     <= is_div ? a_ld : b_ld;
                opnd_q   <= is_div ? b_ld : a_ld;
            end else if (state_q == RUN) begin
                count_q <= count_q + CNT_W'(1);
                acc_q   <= acc_nx;
                sh_q    <= sh_nx;
            end
            if (last) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    always_comb begin
        mf_data = '0;
        if (bus.funct == F_MFHI)      mf_data = hi_q;
        else if (bus.funct == F_MFLO) mf_data = lo_q;
    end

    assign bus.stall   = stall;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.mf_data = mf_data;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_muldiv_ctrl;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.WIDTH(WIDTH)) bus();

    muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t       vecs[12];
    logic [5:0] fsel[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.valid = v;
        bus.funct = f;
        bus.src_a = a;
        bus.src_b = b;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected {HI,LO} straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_model(input logic [5:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
        bit     sgn = 1'b0;
        bit     is_div = (f == 6'd26) || (f == 6'd27);
        longint sa64, sb64;
        int     sa, sb;
`ifdef MULDIV_SIGNED_EN
        sgn = (f == 6'd24) || (f == 6'd26);
`endif
        sa = int'(a);
        sb = int'(b);
        sa64 = longint'(sa);
        sb64 = longint'(sb);
        if (!is_div) begin
            if (sgn) return 64'(sa64 * sb64);
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // Issue one op from IDLE/DONE, scramble operands during RUN, check latency and result.
    task automatic runOp(input string name, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] expected);
        int n;
        applyStimulus(1'b1, f, a, b);
        tick();
        applyStimulus(1'b0, 6'd0, $urandom, $urandom);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            tick();
        end
        checkOutput({name, " busy cycles"}, 64'(n), 64'(WIDTH));
        checkOutput({name, " done"}, 64'(bus.done), 64'd1);
        checkOutput({name, " hi/lo"}, {bus.hi, bus.lo}, expected);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, seen;
        logic [31:0] ra, rb;
        logic [5:0]  rf;

        fsel = '{6'd24, 6'd25, 6'd26, 6'd27};
        vecs[0]  = '{6'd25, 32'd7,          32'd6,          {32'd0, 32'd42}};
        vecs[1]  = '{6'd25, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'hFFFF_FFFE, 32'h0000_0001}};
        vecs[2]  = '{6'd27, 32'd100,        32'd7,          {32'd2, 32'd14}};
        vecs[3]  = '{6'd27, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF}};
        vecs[4]  = '{6'd25, 32'd0,          32'd12345,      64'd0};
        vecs[5]  = '{6'd27, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}};
        vecs[9]  = '{6'd26, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
`ifdef MULDIV_SIGNED_EN
        vecs[6]  = '{6'd26, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[7]  = '{6'd24, 32'hFFFF_FFFD,  32'd4,          {32'hFFFF_FFFF, 32'hFFFF_FFF4}};
        vecs[8]  = '{6'd26, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000}};
        vecs[10] = '{6'd24, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0, 32'd1}};
        vecs[11] = '{6'd26, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD}};
`else
        vecs[6]  = '{6'd26, 32'hFFFF_FFF9,  32'd2,          {32'd1, 32'h7FFF_FFFC}};
        vecs[7]  = '{6'd24, 32'hFFFF_FFFD,  32'd4,          {32'd3, 32'hFFFF_FFF4}};
        vecs[8]  = '{6'd26, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0}};
        vecs[10] = '{6'd24, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'hFFFF_FFFE, 32'd1}};
        vecs[11] = '{6'd26, 32'd7,          32'hFFFF_FFFE,  {32'd7, 32'd0}};
`endif

        // Reset state.
        applyStimulus(1'b1, 6'd16, 32'd0, 32'd0);
        tick();
        tick();
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        checkOutput("reset stall", 64'(bus.stall), 64'd0);
        checkOutput("reset mf_data", 64'(bus.mf_data), 64'd0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();

        // MFLO waiting on an in-flight MULTU sees the new LO in DONE.
        applyStimulus(1'b1, 6'd25, 32'd7, 32'd6);
        tick();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        tick();
        tick();
        applyStimulus(1'b1, 6'd18, 32'd0, 32'd0);
        checkOutput("mflo stall while busy", 64'(bus.stall), 64'd1);
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            tick();
        end
        checkOutput("mflo stall cycles", 64'(n), 64'(WIDTH - 2));
        checkOutput("mflo done at release", 64'(bus.done), 64'd1);
        checkOutput("mflo data in done", 64'(bus.mf_data), 64'd42);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        tick();

        // Unrelated instruction during busy is not stalled; HI/LO reader is.
        applyStimulus(1'b1, 6'd25, 32'd3, 32'd3);
        tick();
        applyStimulus(1'b1, 6'd32, 32'd1, 32'd2);
        checkOutput("add busy", 64'(bus.busy), 64'd1);
        checkOutput("add stall", 64'(bus.stall), 64'd0);
        applyStimulus(1'b1, 6'd16, 32'd1, 32'd2);
        checkOutput("mfhi stall", 64'(bus.stall), 64'd1);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        n = 0;
        while (!bus.done && n < 100) begin
            n++;
            tick();
        end
        checkOutput("3*3 hi/lo", {bus.hi, bus.lo}, 64'd9);
        tick();

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].exp);
            tick();
            checkOutput($sformatf("vec%0d done pulse width", i), 64'(bus.done), 64'd0);
            checkOutput($sformatf("vec%0d idle busy", i), 64'(bus.busy), 64'd0);
            applyStimulus(1'b1, 6'd16, 32'd0, 32'd0);
            checkOutput($sformatf("vec%0d mfhi", i), 64'(bus.mf_data), 64'(vecs[i].exp[63:32]));
            applyStimulus(1'b1, 6'd18, 32'd0, 32'd0);
            checkOutput($sformatf("vec%0d mflo", i), 64'(bus.mf_data), 64'(vecs[i].exp[31:0]));
            checkOutput($sformatf("vec%0d mf stall", i), 64'(bus.stall), 64'd0);
            applyStimulus(1'b1, 6'd32, 32'd0, 32'd0);
            checkOutput($sformatf("vec%0d other mf_data", i), 64'(bus.mf_data), 64'd0);
            applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        end

        // Stalled DIVU accepted in DONE, back-to-back with the MULTU.
        applyStimulus(1'b1, 6'd25, 32'd1000, 32'd3000);
        tick();
        applyStimulus(1'b1, 6'd27, 32'd100, 32'd7);
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            tick();
        end
        checkOutput("b2b first done", 64'(bus.done), 64'd1);
        checkOutput("b2b first hi/lo", {bus.hi, bus.lo}, 64'd3000000);
        tick();
        applyStimulus(1'b0, 6'd0, $urandom, $urandom);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            tick();
        end
        checkOutput("b2b second busy cycles", 64'(n), 64'(WIDTH));
        checkOutput("b2b second hi/lo", {bus.hi, bus.lo}, {32'd2, 32'd14});

        // Randomized ops against the reference model, back-to-back from DONE.
        for (int i = 0; i < 40; i++) begin
            rf = fsel[$urandom_range(0, 3)];
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            runOp($sformatf("rand%0d f=%0d a=%0h b=%0h", i, rf, ra, rb), rf, ra, rb,
                  ref_model(rf, ra, rb));
        end

        // Reset at RUN count 10 aborts without committing.
        tick();
        applyStimulus(1'b1, 6'd25, 32'd7, 32'd6);
        tick();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        checkOutput("abort done", 64'(bus.done), 64'd0);
        checkOutput("abort hi/lo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.done || bus.busy) seen = 1;
        end
        checkOutput("abort no later activity", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
